// File: rtl/uart_mul_ctrl.sv
// Sequencer between the UART byte stream and the multiplier: gathers two big-endian
// operands, pulses start, then streams the product back MSB-first with backpressure.
module uart_mul_ctrl #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic [WIDTH-1:0] mul_a_o,
  output logic [WIDTH-1:0] mul_b_o,
  output logic             mul_start_o,
  input  logic             mul_done_i,
  input  logic [WIDTH-1:0] mul_result_i,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             timeout_o
);

  localparam int N      = WIDTH / 8;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]  LAST      = CNT_W'(N - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    RX_A,
    RX_B,
    MUL,
    TX
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDLE_W-1:0] idle_q;
  logic [WIDTH-1:0]  result_q;

  logic accept, drop, handshake, capture, idle_run, timeout_fire, last_byte;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RX_A;
    end else begin
      state_q <= state_d;
    end
  end

  // idle_q counts completed idle cycles, so the edge closing the TIMEOUT_CYCLES-th one fires
  always_comb begin
    state_d      = state_q;
    last_byte    = (cnt_q == LAST);
    accept       = rx_valid_i && ((state_q == RX_A) || (state_q == RX_B));
    drop         = rx_valid_i && ((state_q == MUL) || (state_q == TX));
    handshake    = (state_q == TX) && tx_ready_i;
    capture      = (state_q == MUL) && mul_done_i && !mul_start_o;
    idle_run     = ((state_q == RX_A) && (cnt_q != '0)) || (state_q == RX_B);
    timeout_fire = TO_EN && idle_run && !rx_valid_i && (idle_q == IDLE_LAST);

    case (state_q)
      RX_A: begin
        if (accept && last_byte) state_d = RX_B;
        else if (timeout_fire)   state_d = RX_A;
      end
      RX_B: begin
        if (accept && last_byte) state_d = MUL;
        else if (timeout_fire)   state_d = RX_A;
      end
      MUL: begin
        if (capture) state_d = TX;
      end
      TX: begin
        if (handshake && last_byte) state_d = RX_A;
      end
      default: state_d = RX_A;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      idle_q      <= '0;
      result_q    <= '0;
      mul_a_o     <= '0;
      mul_b_o     <= '0;
      mul_start_o <= 1'b0;
      overrun_o   <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      mul_start_o <= (state_q == RX_B) && accept && last_byte;
      overrun_o   <= drop;
      timeout_o   <= timeout_fire;

      if (accept && (state_q == RX_A)) mul_a_o <= (mul_a_o << 8) | WIDTH'(rx_data_i);
      if (accept && (state_q == RX_B)) mul_b_o <= (mul_b_o << 8) | WIDTH'(rx_data_i);

      if (accept || handshake) begin
        cnt_q <= last_byte ? '0 : cnt_q + CNT_W'(1);
      end else if (timeout_fire || capture) begin
        cnt_q <= '0;
      end

      if (TO_EN && idle_run && !accept && !timeout_fire) begin
        idle_q <= idle_q + IDLE_W'(1);
      end else begin
        idle_q <= '0;
      end

      if (capture) begin
        result_q <= mul_result_i;
      end else if (handshake) begin
        result_q <= result_q << 8;
      end
    end
  end

  assign tx_data_o  = result_q[WIDTH-1 -: 8];
  assign tx_valid_o = (state_q == TX);
  assign busy_o     = (state_q == MUL) || (state_q == TX);

endmodule
